// File: rtl/custom_leds_pwm.sv
// custom_leds_pwm: Avalon-MM LED driver with per-LED 4-bit PWM brightness and optional global blink.
// Define CUSTOM_LEDS_PWM_BLINK_EN to build the blink frame counter and the BLINK register.
module custom_leds_pwm #(
    parameter logic [15:0] PRESCALE_RST = 16'd999,
    parameter logic [23:0] BLINK_RST    = 24'd100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic [7:0]  leds
);
    localparam int unsigned NUM_LEDS   = 8;
    localparam int unsigned DUTY_W     = 4;
    localparam int unsigned PCNT_W     = 16;
    localparam int unsigned FCNT_W     = 24;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned PHASE_LAST = 14;

    localparam logic [1:0] ADDR_CTRL     = 2'd0;
    localparam logic [1:0] ADDR_DUTY     = 2'd1;
    localparam logic [1:0] ADDR_PRESCALE = 2'd2;
    localparam logic [1:0] ADDR_BLINK    = 2'd3;

    logic                          en;
    logic [DATA_W-1:0]             duty_wr;
    logic [DATA_W-1:0]             duty_act;
    logic [PCNT_W-1:0]             prescale;
    logic [PCNT_W-1:0]             pcnt;
    logic [DUTY_W-1:0]             phase;
    logic                          blink_en;
    logic [FCNT_W-1:0]             blink;
    logic                          tick;
    logic                          frame;
    logic                          blank;
    logic                          wr_ctrl;
    logic                          wr_duty;
    logic                          wr_prescale;
    logic                          wr_blink;
    logic [NUM_LEDS-1:0]           leds_nxt;
    logic [DATA_W-1:0]             rd_mux;

    // Write decode and prescaler/frame strobes
    always_comb begin
        wr_ctrl     = avs_write && (avs_address == ADDR_CTRL);
        wr_duty     = avs_write && (avs_address == ADDR_DUTY);
        wr_prescale = avs_write && (avs_address == ADDR_PRESCALE);
        wr_blink    = avs_write && (avs_address == ADDR_BLINK);
        tick        = en && (pcnt >= prescale);
        frame       = tick && (phase == DUTY_W'(PHASE_LAST));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en       <= 1'b0;
            duty_wr  <= '0;
            prescale <= PRESCALE_RST;
        end else begin
            if (wr_ctrl)     en       <= avs_writedata[0];
            if (wr_duty)     duty_wr  <= avs_writedata;
            if (wr_prescale) prescale <= avs_writedata[PCNT_W-1:0];
        end
    end

    // Prescaler, phase and duty shadow; all parked while disabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt     <= '0;
            phase    <= '0;
            duty_act <= '0;
        end else if (!en) begin
            pcnt     <= '0;
            phase    <= '0;
            duty_act <= duty_wr;
        end else begin
            pcnt <= tick ? '0 : pcnt + PCNT_W'(1);
            if (tick) phase <= frame ? '0 : phase + DUTY_W'(1);
            if (frame) duty_act <= duty_wr;
        end
    end

`ifdef CUSTOM_LEDS_PWM_BLINK_EN
    logic [FCNT_W-1:0] fcnt;
    logic              bstate;

    // Blink half-period counted in whole PWM frames
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_en <= 1'b0;
            blink    <= BLINK_RST;
            fcnt     <= '0;
            bstate   <= 1'b0;
        end else begin
            if (wr_ctrl)  blink_en <= avs_writedata[1];
            if (wr_blink) blink    <= avs_writedata[FCNT_W-1:0];
            if (!en) begin
                fcnt   <= '0;
                bstate <= 1'b0;
            end else if (frame) begin
                if (fcnt >= blink) begin
                    fcnt   <= '0;
                    bstate <= ~bstate;
                end else begin
                    fcnt <= fcnt + FCNT_W'(1);
                end
            end
        end
    end

    always_comb blank = blink_en && bstate;
`else
    logic unused_blink;

    always_comb begin
        blink_en = 1'b0;
        blink    = '0;
        blank    = 1'b0;
    end

    assign unused_blink = ^{BLINK_RST, wr_blink};
`endif

    always_comb begin
        leds_nxt = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            leds_nxt[i] = en && (phase < duty_act[i*DUTY_W +: DUTY_W]) && !blank;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_CTRL:     rd_mux = {30'd0, blink_en, en};
            ADDR_DUTY:     rd_mux = duty_wr;
            ADDR_PRESCALE: rd_mux = {16'd0, prescale};
            default:       rd_mux = {8'd0, blink};
        endcase
    end

    // Registered LED drive and read data (held between reads)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leds         <= '0;
            avs_readdata <= '0;
        end else begin
            leds <= leds_nxt;
            if (avs_read) avs_readdata <= rd_mux;
        end
    end
endmodule

// File: tb/tb_custom_leds_pwm.sv
// Self-checking bench for custom_leds_pwm: directed scenarios plus randomized configs vs. an arithmetic model.
module tb_custom_leds_pwm;
    logic        clk;
    logic        reset;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic [7:0]  leds;

    int total = 0;
    int bad   = 0;

`ifdef CUSTOM_LEDS_PWM_BLINK_EN
    localparam bit HAS_BLINK = 1'b1;
`else
    localparam bit HAS_BLINK = 1'b0;
`endif

    custom_leds_pwm dut (
        .clk          (clk),
        .reset        (reset),
        .avs_address  (avs_address),
        .avs_read     (avs_read),
        .avs_write    (avs_write),
        .avs_writedata(avs_writedata),
        .avs_readdata (avs_readdata),
        .leds         (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write     = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        avs_address = a;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read    = 1'b0;
        d = avs_readdata;
    endtask

    // LEDs for counting index k (cycles since enable), from frame arithmetic
    function automatic logic [7:0] model_leds(input int unsigned k, input int unsigned p,
                                              input int unsigned b, input logic [31:0] d,
                                              input logic be);
        int unsigned ph;
        int unsigned f;
        logic        blank;
        logic [7:0]  r;
        logic [3:0]  du;
        ph    = (k / (p + 1)) % 15;
        f     = k / (15 * (p + 1));
        blank = HAS_BLINK && be && (((f / (b + 1)) % 2) == 1);
        for (int i = 0; i < 8; i++) begin
            du   = d[4*i +: 4];
            r[i] = !blank && (int'(du) > int'(ph));
        end
        return r;
    endfunction

    task automatic test_reset();
        logic [31:0] rd;
        logic [31:0] exp_rd [4];
        exp_rd[0] = 32'd0;
        exp_rd[1] = 32'd0;
        exp_rd[2] = 32'd999;
        exp_rd[3] = HAS_BLINK ? 32'd100 : 32'd0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (leds !== 8'h00 || avs_readdata !== 32'd0) begin
            bad++;
            $display("FAIL reset_state leds=%h rdata=%h want 00/0", leds, avs_readdata);
        end
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            read_reg(2'(a), rd);
            total++;
            if (rd !== exp_rd[a] || leds !== 8'h00) begin
                bad++;
                $display("FAIL reset_read addr=%0d got=%0d want=%0d leds=%h", a, rd, exp_rd[a], leds);
            end
        end
    endtask

    task automatic test_rw_same_cycle();
        logic [31:0] rd;
        @(negedge clk);
        avs_address   = 2'd2;
        avs_writedata = 32'd7;
        avs_read      = 1'b1;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_read  = 1'b0;
        avs_write = 1'b0;
        total++;
        if (avs_readdata !== 32'd999) begin
            bad++;
            $display("FAIL rw_same_cycle got=%0d want=999", avs_readdata);
        end
        repeat (2) @(negedge clk);
        total++;
        if (avs_readdata !== 32'd999) begin
            bad++;
            $display("FAIL rdata_hold got=%0d want=999", avs_readdata);
        end
        read_reg(2'd2, rd);
        total++;
        if (rd !== 32'd7) begin
            bad++;
            $display("FAIL rw_after_write got=%0d want=7", rd);
        end
    endtask

    task automatic test_duty_frame();
        int cnt [8];
        int want [8];
        want = '{0, 0, 0, 0, 1, 4, 8, 15};
        for (int i = 0; i < 8; i++) cnt[i] = 0;
        write_reg(2'd0, 32'd0);
        write_reg(2'd2, 32'd0);
        write_reg(2'd1, 32'hF841_0000);
        write_reg(2'd0, 32'd1);
        for (int j = 1; j <= 15; j++) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) cnt[i] += int'(leds[i]);
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (cnt[i] != want[i]) begin
                bad++;
                $display("FAIL duty_frame led%0d high=%0d want=%0d", i, cnt[i], want[i]);
            end
        end
    endtask

    task automatic test_midframe_duty();
        int c1 = 0;
        int c2 = 0;
        write_reg(2'd0, 32'd0);
        write_reg(2'd2, 32'd0);
        write_reg(2'd1, 32'h0000_000F);
        write_reg(2'd0, 32'd1);
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk);
            if (j <= 15) c1 += int'(leds[0]);
            else         c2 += int'(leds[0]);
            if (j == 5) begin
                avs_address   = 2'd1;
                avs_writedata = 32'h0000_0003;
                avs_write     = 1'b1;
            end
            if (j == 6) avs_write = 1'b0;
        end
        total++;
        if (c1 != 15) begin
            bad++;
            $display("FAIL midframe_cur high=%0d want=15", c1);
        end
        total++;
        if (c2 != 3) begin
            bad++;
            $display("FAIL midframe_next high=%0d want=3", c2);
        end
    endtask

    task automatic test_prescale_shrink();
        int c0 = 0;
        int c1 = 0;
        int c2 = 0;
        write_reg(2'd0, 32'd0);
        write_reg(2'd2, 32'd100);
        write_reg(2'd1, 32'h0000_0321);
        write_reg(2'd0, 32'd1);
        for (int j = 1; j <= 100; j++) begin
            @(negedge clk);
            c0 += int'(leds[0]);
            c1 += int'(leds[1] & ~leds[0]);
            c2 += int'(leds[2] & ~leds[1]);
            if (j == 50) begin
                avs_address   = 2'd2;
                avs_writedata = 32'd10;
                avs_write     = 1'b1;
            end
            if (j == 51) avs_write = 1'b0;
        end
        total++;
        if (c0 != 52) begin
            bad++;
            $display("FAIL prescale_wrap phase0_len=%0d want=52", c0);
        end
        total++;
        if (c1 != 11 || c2 != 11) begin
            bad++;
            $display("FAIL prescale_period p1=%0d p2=%0d want=11", c1, c2);
        end
    endtask

    task automatic test_blink();
        logic [31:0] rd;
        logic [7:0]  exp_l;
        int          errs = 0;
        write_reg(2'd0, 32'd0);
        write_reg(2'd2, 32'd0);
        write_reg(2'd1, 32'hFFFF_FFFF);
        write_reg(2'd3, 32'd1);
        write_reg(2'd0, 32'd3);
        for (int j = 1; j <= 90; j++) begin
            @(negedge clk);
            exp_l = (HAS_BLINK && ((((j - 1) / 30) % 2) == 1)) ? 8'h00 : 8'hFF;
            if (leds !== exp_l) begin
                errs++;
                if (errs <= 4) $display("FAIL blink cycle=%0d leds=%h want=%h", j, leds, exp_l);
            end
        end
        total++;
        if (errs != 0) bad++;
        read_reg(2'd3, rd);
        total++;
        if (rd !== (HAS_BLINK ? 32'd1 : 32'd0)) begin
            bad++;
            $display("FAIL blink_reg got=%0d want=%0d", rd, HAS_BLINK ? 1 : 0);
        end
        read_reg(2'd0, rd);
        total++;
        if (rd !== (HAS_BLINK ? 32'd3 : 32'd1)) begin
            bad++;
            $display("FAIL ctrl_read got=%0d want=%0d", rd, HAS_BLINK ? 3 : 1);
        end
    endtask

    task automatic test_random();
        int unsigned p;
        int unsigned b;
        logic [31:0] d;
        logic [31:0] rd;
        logic        be;
        logic [7:0]  exp_l;
        for (int it = 0; it < 8; it++) begin
            p  = $urandom_range(0, 3);
            b  = $urandom_range(0, 2);
            d  = $urandom;
            be = 1'($urandom_range(0, 1));
            write_reg(2'd0, 32'd0);
            write_reg(2'd2, p);
            write_reg(2'd1, d);
            write_reg(2'd3, b);
            write_reg(2'd0, {30'd0, be, 1'b1});
            for (int j = 1; j <= 200; j++) begin
                @(negedge clk);
                exp_l = model_leds(j - 1, p, b, d, be);
                total++;
                if (leds !== exp_l) begin
                    bad++;
                    $display("FAIL random it=%0d k=%0d p=%0d b=%0d be=%0b leds=%h want=%h",
                             it, j - 1, p, b, be, leds, exp_l);
                end
            end
            read_reg(2'd1, rd);
            total++;
            if (rd !== d) begin
                bad++;
                $display("FAIL duty_read got=%h want=%h", rd, d);
            end
            write_reg(2'd0, 32'd0);
            @(negedge clk);
            total++;
            if (leds !== 8'h00) begin
                bad++;
                $display("FAIL disable leds=%h want=00", leds);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] rd;
        int          lit = 0;
        write_reg(2'd0, 32'd0);
        write_reg(2'd2, 32'd0);
        write_reg(2'd1, 32'hFFFF_FFFF);
        write_reg(2'd0, 32'd1);
        repeat (5) @(negedge clk);
        total++;
        if (leds !== 8'hFF) begin
            bad++;
            $display("FAIL pre_reset leds=%h want=ff", leds);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (leds !== 8'h00) begin
            bad++;
            $display("FAIL async_reset leds=%h want=00", leds);
        end
        @(negedge clk);
        reset = 1'b0;
        read_reg(2'd0, rd);
        total++;
        if (rd !== 32'd0) begin
            bad++;
            $display("FAIL post_reset_ctrl got=%0d want=0", rd);
        end
        read_reg(2'd2, rd);
        total++;
        if (rd !== 32'd999) begin
            bad++;
            $display("FAIL post_reset_prescale got=%0d want=999", rd);
        end
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (leds !== 8'h00) lit++;
        end
        total++;
        if (lit != 0) begin
            bad++;
            $display("FAIL post_reset_leds lit_cycles=%0d want=0", lit);
        end
    endtask

    initial begin
        reset         = 1'b1;
        avs_address   = 2'd0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = 32'd0;
        test_reset();
        test_rw_same_cycle();
        test_duty_frame();
        test_midframe_duty();
        test_prescale_shrink();
        test_blink();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
